// File: rtl/demux8_buffer.sv
// demux8_buffer: registered 1-to-8 demultiplexer with per-destination holding slots.
// A producer word is steered into slot sel and held there until consumer sel acks it.
// Every slot drains on its own schedule. A slot that is acked in the same cycle it is
// written passes the new word straight through, with no bubble between words.
module demux8_buffer #(
    parameter int width = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           sel,
    input  logic [width-1:0]     din,
    input  logic                 flush,
    output logic [8*width-1:0]   out_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ack,
    output logic [3:0]           count
);

    logic       accept;
    logic [7:0] next_valid;
    logic [3:0] next_count;

    // Only the addressed slot can block the producer. in_ready is also held low
    // during flush and while reset is asserted.
    always_comb begin
        in_ready = reset_n & ~flush & (~out_valid[sel] | out_ack[sel]);
        accept   = in_valid & in_ready;
    end

    // Next slot occupancy: acks clear first, then an accept sets its slot. Flush
    // overrides both. The population count is formed here so it registers in step.
    always_comb begin
        next_valid = out_valid & ~out_ack;
        if (accept) begin
            next_valid[sel] = 1'b1;
        end
        if (flush) begin
            next_valid = 8'h00;
        end
        next_count = 4'd0;
        for (int k = 0; k < 8; k++) begin
            next_count = next_count + {3'b000, next_valid[k]};
        end
    end

    // Slot flags and the occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 8'h00;
            count     <= 4'd0;
        end else begin
            out_valid <= next_valid;
            count     <= next_count;
        end
    end

    // Slot data loads only on accept. An acked or flushed slot keeps its stale word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (accept && (sel == 3'(k))) begin
                    out_data[k*width +: width] <= din;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux8_buffer.sv
// tb_demux8_buffer: directed scenarios plus a randomized run.
// All expected values come from a slot-array reference model kept in this bench.
module tb_demux8_buffer;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     sel;
    logic [W-1:0]   din;
    logic           flush;
    logic [8*W-1:0] out_data;
    logic [7:0]     out_valid;
    logic [7:0]     out_ack;
    logic [3:0]     count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: one valid flag and one data word per slot
    bit           mv [8];
    logic [W-1:0] md [8];
    bit           last_acc;

    demux8_buffer #(.width(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .din       (din),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_valid();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = mv[k];
        return v;
    endfunction

    function automatic logic [3:0] exp_count();
        int c;
        c = 0;
        for (int k = 0; k < 8; k++) if (mv[k]) c++;
        return 4'(c);
    endfunction

    function automatic logic [8*W-1:0] exp_data();
        logic [8*W-1:0] d;
        for (int k = 0; k < 8; k++) d[k*W +: W] = md[k];
        return d;
    endfunction

    function automatic logic exp_ready();
        return reset_n && !flush && (!mv[sel] || out_ack[sel]);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
    endtask

    task automatic drive(input logic iv, input logic [2:0] s, input logic [W-1:0] d,
                         input logic fl, input logic [7:0] ack);
        in_valid = iv;
        sel      = s;
        din      = d;
        flush    = fl;
        out_ack  = ack;
        #1;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = in_valid && !flush && (!mv[sel] || out_ack[sel]);
        for (int k = 0; k < 8; k++) begin
            if (flush) mv[k] = 1'b0;
            else if (out_ack[k]) mv[k] = 1'b0;
        end
        if (acc && !flush) begin
            mv[sel] = 1'b1;
            md[sel] = din;
        end
        last_acc = acc;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 3'd0, 32'h1111_1111, 1'b0, 8'h00);
        n_checks++;
        if (out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid got %h want 00", out_valid); end
        n_checks++;
        if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++;
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", in_ready); end
        drive(1'b0, 3'd0, '0, 1'b0, 8'h00);
        #4 reset_n = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, 8'h00);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", in_ready); end
        tick();
        drive(1'b0, 3'd0, '0, 1'b0, 8'h00);
        n_checks++;
        if (out_valid !== 8'h08) begin n_fail++; $display("FAIL single_valid got %h want 08", out_valid); end
        n_checks++;
        if (out_data[3*W +: W] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_slot3 got %h want deadbeef", out_data[3*W +: W]); end
        n_checks++;
        if (count !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
        n_checks++;
        if (out_data !== exp_data()) begin n_fail++; $display("FAIL single_others got %h want %h", out_data, exp_data()); end
    endtask

    task automatic test_fill();
        drive(1'b0, 3'd0, '0, 1'b1, 8'h00);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), 32'(k), 1'b0, 8'h00);
            tick();
        end
        drive(1'b0, 3'd0, '0, 1'b0, 8'h00);
        n_checks++;
        if (out_valid !== 8'hFF) begin n_fail++; $display("FAIL fill_valid got %h want ff", out_valid); end
        n_checks++;
        if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d want 8", count); end
        drive(1'b1, 3'd5, 32'hBAD0_0005, 1'b0, 8'h00);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", in_ready); end
        tick();
        drive(1'b0, 3'd0, '0, 1'b0, 8'h00);
        n_checks++;
        if (out_data[5*W +: W] !== 32'h5) begin n_fail++; $display("FAIL full_slot5 got %h want 5", out_data[5*W +: W]); end
        n_checks++;
        if (count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d want 8", count); end
    endtask

    task automatic test_pass_through();
        // slots still full from the fill scenario
        drive(1'b1, 3'd2, 32'h1234, 1'b0, 8'h04);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pass_ready got %b want 1", in_ready); end
        tick();
        drive(1'b0, 3'd0, '0, 1'b0, 8'h00);
        n_checks++;
        if (out_valid !== 8'hFF) begin n_fail++; $display("FAIL pass_valid got %h want ff", out_valid); end
        n_checks++;
        if (out_data[2*W +: W] !== 32'h1234) begin n_fail++; $display("FAIL pass_slot2 got %h want 1234", out_data[2*W +: W]); end
        n_checks++;
        if (count !== 4'd8) begin n_fail++; $display("FAIL pass_count got %0d want 8", count); end
    endtask

    task automatic test_multi_ack();
        drive(1'b0, 3'd0, '0, 1'b1, 8'h00);
        tick();
        drive(1'b1, 3'd1, 32'hA1, 1'b0, 8'h00);
        tick();
        drive(1'b1, 3'd6, 32'hA6, 1'b0, 8'h00);
        tick();
        drive(1'b1, 3'd4, 32'hA4, 1'b0, 8'h43);
        tick();
        drive(1'b0, 3'd0, '0, 1'b0, 8'h00);
        n_checks++;
        if (out_valid !== 8'h10) begin n_fail++; $display("FAIL multi_valid got %h want 10", out_valid); end
        n_checks++;
        if (count !== 4'd1) begin n_fail++; $display("FAIL multi_count got %0d want 1", count); end
        n_checks++;
        if (out_data !== exp_data()) begin n_fail++; $display("FAIL multi_data got %h want %h", out_data, exp_data()); end
    endtask

    task automatic test_flush();
        drive(1'b0, 3'd0, '0, 1'b1, 8'h00);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'(k), 32'hF0 + 32'(k), 1'b0, 8'h00);
            tick();
        end
        drive(1'b1, 3'd7, 32'h7777_7777, 1'b1, 8'h00);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", in_ready); end
        tick();
        drive(1'b0, 3'd0, '0, 1'b0, 8'h00);
        n_checks++;
        if (out_valid !== 8'h00) begin n_fail++; $display("FAIL flush_valid got %h want 00", out_valid); end
        n_checks++;
        if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
        n_checks++;
        if (out_data[7*W +: W] === 32'h7777_7777) begin n_fail++; $display("FAIL flush_slot7 got %h want not 77777777", out_data[7*W +: W]); end
        n_checks++;
        if (out_data !== exp_data()) begin n_fail++; $display("FAIL flush_data got %h want %h", out_data, exp_data()); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 3'd4, 32'hC4, 1'b0, 8'h00);
        tick();
        drive(1'b1, 3'd5, 32'hC5, 1'b0, 8'h00);
        tick();
        drive(1'b0, 3'd0, '0, 1'b0, 8'h00);
        n_checks++;
        if (out_valid !== 8'h30) begin n_fail++; $display("FAIL prereset_valid got %h want 30", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (out_valid !== 8'h00) begin n_fail++; $display("FAIL areset_valid got %h want 00", out_valid); end
        n_checks++;
        if (out_data !== '0) begin n_fail++; $display("FAIL areset_data got %h want 0", out_data); end
        n_checks++;
        if (count !== 4'd0) begin n_fail++; $display("FAIL areset_count got %0d want 0", count); end
        #2 reset_n = 1'b1;
        drive(1'b1, 3'd0, 32'h0BAD_CAFE, 1'b0, 8'h00);
        tick();
        drive(1'b0, 3'd0, '0, 1'b0, 8'h00);
        n_checks++;
        if (out_valid !== 8'h01) begin n_fail++; $display("FAIL postreset_valid got %h want 01", out_valid); end
        n_checks++;
        if (out_data !== exp_data()) begin n_fail++; $display("FAIL postreset_data got %h want %h", out_data, exp_data()); end
        n_checks++;
        if (count !== 4'd1) begin n_fail++; $display("FAIL postreset_count got %0d want 1", count); end
    endtask

    task automatic test_random();
        bit           pending;
        logic         iv;
        logic [2:0]   s;
        logic [W-1:0] d;
        pending = 1'b0;
        iv = 1'b0;
        s = '0;
        d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                iv = ($urandom_range(0, 3) != 0);
                s  = 3'($urandom_range(0, 7));
                d  = $urandom;
            end
            drive(iv, s, d, ($urandom_range(0, 19) == 0), 8'($urandom) & 8'($urandom));
            n_checks++;
            if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", i, in_ready, exp_ready()); end
            tick();
            pending = iv && !last_acc;
            n_checks++;
            if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rand_valid cyc %0d got %h want %h", i, out_valid, exp_valid()); end
            n_checks++;
            if (count !== exp_count()) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d want %0d", i, count, exp_count()); end
            n_checks++;
            if (out_data !== exp_data()) begin n_fail++; $display("FAIL rand_data cyc %0d got %h want %h", i, out_data, exp_data()); end
        end
        drive(1'b0, 3'd0, '0, 1'b0, 8'h00);
    endtask

    initial begin
        reset_n  = 1'b0;
        last_acc = 1'b0;
        model_clear();
        drive(1'b0, 3'd0, '0, 1'b0, 8'h00);
        #2;
        test_reset();
        test_single();
        test_fill();
        test_pass_through();
        test_multi_ack();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so a stalled run still terminates with a report.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
